// File: rtl/i2s_dac_tx.sv
// Stereo I2S transmitter for a PCM5102-class DAC.
// A valid/ready port fills a one-pair holding buffer. Each 64-BCK frame loads the
// buffered pair into the frame registers and shifts it out MSB-first, one bit per
// BCK, with LRCK low for the left slot and high for the right slot.
// The MSB of each slot follows the LRCK edge by one BCK, which is standard I2S.
// When no new pair is waiting at a frame boundary, the previous pair repeats and
// underrun pulses for one clk.
module i2s_dac_tx #(
    parameter int w_sample = 16,
    parameter int bck_half = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [w_sample-1:0] left,
    input  logic [w_sample-1:0] right,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bck,
    output logic                lrck,
    output logic                dout,
    output logic                underrun
);

    localparam int               DIV_W    = (bck_half > 1) ? $clog2(bck_half) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(bck_half - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          bit_cnt;
    logic [5:0]          bit_nxt;
    logic                tick;
    logic                fall;
    logic                load;
    logic                accept;
    logic [w_sample-1:0] buf_l;
    logic [w_sample-1:0] buf_r;
    logic [w_sample-1:0] frame_l;
    logic [w_sample-1:0] frame_r;

    // Bit of a slot at position pos.
    // Position 0 is the one-BCK I2S delay. Positions 1..w_sample carry the word
    // MSB first. Positions above w_sample are zero padding.
    function automatic logic slot_bit(input logic [w_sample-1:0] word,
                                      input logic [4:0]          pos);
        logic [w_sample-1:0] shifted;
        shifted = word >> (6'(w_sample) - {1'b0, pos});
        if (pos == 5'd0 || {1'b0, pos} > 6'(w_sample)) begin
            return 1'b0;
        end
        return shifted[0];
    endfunction

    assign tick    = (div_cnt == DIV_LAST);
    assign fall    = tick && bck;
    assign bit_nxt = bit_cnt + 6'd1;
    assign load    = fall && (bit_nxt == 6'd0);
    assign accept  = sample_valid && sample_ready;

    // BCK divider: toggle bck every bck_half clks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            bck     <= ~bck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // On each BCK falling edge, advance the frame position and drive lrck and dout.
    // Position 0 is the edge where the frame registers reload, so the word is not
    // read in that clk. The register update lands before position 1 is serialized.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 6'd63;
            lrck    <= 1'b1;
            dout    <= 1'b0;
        end else if (fall) begin
            bit_cnt <= bit_nxt;
            lrck    <= bit_nxt[5];
            dout    <= slot_bit(bit_nxt[5] ? frame_r : frame_l, bit_nxt[4:0]);
        end
    end

    // Buffer-empty flag, which doubles as sample_ready, and the underrun pulse.
    // An accept can only occur while the buffer is empty. A load can only empty a
    // full buffer. The two updates therefore never conflict.
    // An accept on an empty-buffer load edge fills the buffer for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_ready <= 1'b1;
            underrun     <= 1'b0;
        end else begin
            underrun <= load && sample_ready;
            if (load && !sample_ready) begin
                sample_ready <= 1'b1;
            end else if (accept) begin
                sample_ready <= 1'b0;
            end
        end
    end

    // Frame registers: take the buffered pair at a frame boundary, otherwise hold
    // the previous pair so that it repeats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_l <= '0;
            frame_r <= '0;
        end else if (load && !sample_ready) begin
            frame_l <= buf_l;
            frame_r <= buf_r;
        end
    end

    // Holding buffer data.
    // Its contents matter only while the empty flag is clear, so reset does not
    // touch it.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_l <= left;
            buf_r <= right;
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx.
// Two configurations run side by side: 16-bit samples with bck_half=4, and
// 24-bit samples with bck_half=1.
// Each configuration has three parts:
//   - a frame-level reference model, which pushes the expected {lrck,dout} bit
//     stream of every frame into a queue at each frame load;
//   - a monitor, which pops one entry per BCK rising edge;
//   - a stimulus process, which drives the handshake.
module tb_i2s_dac_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input int cfg_id, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cfg%0d %s got=%0h want=%0h", cfg_id, name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int W = (g == 0) ? 16 : 24;
        localparam int H = (g == 0) ? 4 : 1;
        localparam int F = 128 * H;

        logic         rst_n = 1'b1;
        logic [W-1:0] left  = '0;
        logic [W-1:0] right = '0;
        logic         valid = 1'b0;
        logic         ready;
        logic         bck;
        logic         lrck;
        logic         dout;
        logic         underrun;
        logic         fin = 1'b0;

        i2s_dac_tx #(.w_sample(W), .bck_half(H)) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .left         (left),
            .right        (right),
            .sample_valid (valid),
            .sample_ready (ready),
            .bck          (bck),
            .lrck         (lrck),
            .dout         (dout),
            .underrun     (underrun)
        );

        // Model state.
        // n counts clk edges since release. m counts BCK falls. pos is the frame
        // position reached at the last fall.
        int           n = 0;
        int           m = 0;
        int           pos = 63;
        logic         mfull = 1'b0;
        logic [W-1:0] mbl = '0;
        logic [W-1:0] mbr = '0;
        logic [W-1:0] mfl = '0;
        logic [W-1:0] mfr = '0;
        logic         exp_under = 1'b0;
        logic         just_loaded = 1'b0;
        logic         loaded = 1'b0;
        logic         acc = 1'b0;
        logic [1:0]   bitq [$];

        // Reference model.
        // A fall occurs every 2*H edges, and every 64th fall starts a frame.
        // At each frame start the model pushes 64 expected {lrck,dout} bits.
        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    n = 0; m = 0; pos = 63; mfull = 1'b0;
                    mfl = '0; mfr = '0;
                    exp_under = 1'b0; just_loaded = 1'b0; loaded = 1'b0; acc = 1'b0;
                    bitq.delete();
                end else begin
                    n++;
                    exp_under = 1'b0;
                    just_loaded = 1'b0;
                    acc = valid && !mfull;
                    if (n % (2 * H) == 0) begin
                        m++;
                        pos = (m - 1) % 64;
                        if (pos == 0) begin
                            just_loaded = 1'b1;
                            loaded = 1'b1;
                            if (mfull) begin
                                mfl = mbl; mfr = mbr; mfull = 1'b0;
                            end else begin
                                exp_under = 1'b1;
                            end
                            for (int s = 0; s < 2; s++) begin
                                for (int p = 0; p < 32; p++) begin
                                    logic [W-1:0] word;
                                    logic         b;
                                    word = (s == 1) ? mfr : mfl;
                                    b = 1'b0;
                                    if (p >= 1 && p <= W) begin
                                        word = word >> (W - p);
                                        b = word[0];
                                    end
                                    bitq.push_back({(s == 1), b});
                                end
                            end
                        end
                    end
                    if (acc) begin
                        mbl = left; mbr = right; mfull = 1'b1;
                    end
                end
            end
        end

        // Monitor.
        // Every clk it compares bck, ready and underrun with the model.
        // On each BCK rise after the first frame load it pops one expected bit.
        initial begin
            logic       prev;
            logic [1:0] e;
            prev = 1'b0;
            forever begin
                @(negedge clk);
                check(g, "bck", 32'(bck), 32'((n / H) % 2));
                check(g, "ready", 32'(ready), 32'(!mfull));
                check(g, "underrun", 32'(underrun), 32'(exp_under));
                if (bck && !prev && loaded) begin
                    check(g, "bitq_avail", 32'(bitq.size() > 0), 1);
                    if (bitq.size() > 0) begin
                        e = bitq.pop_front();
                        check(g, "lrck", 32'(lrck), 32'(e[1]));
                        check(g, "dout", 32'(dout), 32'(e[0]));
                    end
                end
                prev = bck;
            end
        end

        task automatic wait_load();
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!just_loaded && t < 2 * F);
            check(g, "load_wait", 32'(just_loaded), 1);
        endtask

        // Stimulus.
        initial begin
            int ucount;
            int accepted;
            int gap;
            int t;

            // Reset defaults, then the first frame with nothing offered.
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            check(g, "rst_bck", 32'(bck), 0);
            check(g, "rst_lrck", 32'(lrck), 1);
            check(g, "rst_dout", 32'(dout), 0);
            check(g, "rst_ready", 32'(ready), 1);
            check(g, "rst_underrun", 32'(underrun), 0);
            rst_n = 1'b1;
            wait_load();
            check(g, "first_load_underrun", 32'(underrun), 1);
            check(g, "first_load_lrck", 32'(lrck), 0);

            // Fixed pair before the first load, followed by a steady stream.
            #2 rst_n = 1'b0;
            repeat (2) @(negedge clk);
            left  = W'(32'hA5C3A5C3 >> (32 - W));
            right = W'((1 << (W - 1)) | 1);
            valid = 1'b1;
            rst_n = 1'b1;
            accepted = 0; ucount = 0; gap = 0; t = 0;
            while (accepted < 11 && t < 14 * F) begin
                @(negedge clk);
                t++;
                if (underrun) ucount++;
                if (valid && acc) begin
                    valid = 1'b0;
                    accepted++;
                    gap = int'($urandom_range(F / 4));
                end else if (!valid && accepted < 11) begin
                    if (gap > 0) begin
                        gap--;
                    end else begin
                        left  = W'($urandom);
                        right = W'($urandom);
                        valid = 1'b1;
                    end
                end
            end
            valid = 1'b0;
            check(g, "stream_accepts", 32'(accepted), 11);
            t = 0;
            do begin
                @(negedge clk);
                t++;
                if (underrun) ucount++;
            end while (!just_loaded && t < 2 * F);
            check(g, "stream_underruns", 32'(ucount), 0);

            // Source stops: the last pair repeats with an underrun pulse.
            wait_load();
            check(g, "repeat_underrun", 32'(underrun), 1);

            // Offer a pair exactly on a load edge.
            t = 0;
            while (!(((n + 1) % (2 * H) == 0) && (m % 64 == 0)) && t < 2 * F) begin
                @(negedge clk);
                t++;
            end
            left  = W'($urandom);
            right = W'($urandom);
            valid = 1'b1;
            @(negedge clk);
            check(g, "edge_offer_underrun", 32'(underrun), 1);
            check(g, "edge_offer_ready", 32'(ready), 0);
            valid = 1'b0;
            wait_load();
            check(g, "edge_offer_played", 32'(underrun), 0);
            wait_load();

            // Mid-frame reset at position 40 with the buffer full.
            left  = W'($urandom);
            right = W'($urandom);
            valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            check(g, "mid_buffer_full", 32'(ready), 0);
            t = 0;
            while (pos != 40 && t < 2 * F) begin
                @(negedge clk);
                t++;
            end
            check(g, "reached_bit40", 32'(pos), 40);
            #2 rst_n = 1'b0;
            #1;
            check(g, "async_bck", 32'(bck), 0);
            check(g, "async_lrck", 32'(lrck), 1);
            check(g, "async_dout", 32'(dout), 0);
            check(g, "async_ready", 32'(ready), 1);
            check(g, "async_underrun", 32'(underrun), 0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            wait_load();
            check(g, "post_reset_underrun", 32'(underrun), 1);
            wait_load();
            check(g, "bitq_level", 32'(bitq.size()), 64);
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(cfg[0].fin && cfg[1].fin) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        check(0, "all_done", 32'(cfg[0].fin && cfg[1].fin), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
